// File: rtl/i2c_xfer_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_xfer_sequencer
//
// Autonomous APB master that drives the APB I2C master peripheral through
// complete register-style I2C transactions: device address, register address,
// then one data byte written or read. After reset it initialises the core
// once (prescaler, then core enable), then serves one request at a time and
// reports read data plus an error code.
//
// Ports
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake; req_rnw selects read (1)/write (0)
//   req_dev/req_reg        7-bit device address, 8-bit device register
//   req_wdata              byte to write
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata/rsp_err      read byte (0 unless a successful read);
//                          err 00 ok, 01 NACK, 10 arbitration lost,
//                          11 timeout or PSLVERR
//   PADDR..PSLVERR         APB master port to the I2C peripheral
// -----------------------------------------------------------------------------
module i2c_xfer_sequencer #(
   parameter int          APB_ADDR_WIDTH = 12,
   parameter logic [15:0] PRESCALE       = 16'd99,
   parameter int          POLL_LIMIT     = 4096
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_rnw,
   input  logic [6:0]                req_dev,
   input  logic [7:0]                req_reg,
   input  logic [7:0]                req_wdata,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [7:0]                rsp_rdata,
   output logic [1:0]                rsp_err,
   output logic [APB_ADDR_WIDTH-1:0] PADDR,
   output logic [31:0]               PWDATA,
   output logic                      PWRITE,
   output logic                      PSEL,
   output logic                      PENABLE,
   input  logic [31:0]               PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

   localparam int CW = $clog2(POLL_LIMIT + 1);
   localparam logic [CW-1:0] POLL_MAX = CW'(POLL_LIMIT);

   localparam logic [APB_ADDR_WIDTH-1:0] A_PRE    = APB_ADDR_WIDTH'(8'h00);
   localparam logic [APB_ADDR_WIDTH-1:0] A_CTRL   = APB_ADDR_WIDTH'(8'h04);
   localparam logic [APB_ADDR_WIDTH-1:0] A_RX     = APB_ADDR_WIDTH'(8'h08);
   localparam logic [APB_ADDR_WIDTH-1:0] A_STATUS = APB_ADDR_WIDTH'(8'h0C);
   localparam logic [APB_ADDR_WIDTH-1:0] A_TX     = APB_ADDR_WIDTH'(8'h10);
   localparam logic [APB_ADDR_WIDTH-1:0] A_CMD    = APB_ADDR_WIDTH'(8'h14);

   // Each state that touches the bus owns exactly one APB access; the state
   // advances when that access completes.
   typedef enum logic [3:0] {
      S_PRE, S_CTRL, S_IDLE, S_TX, S_CMD, S_POLL, S_RX, S_ABCMD, S_ABPOLL, S_DONE
   } state_t;

   state_t                    state_q, state_d;
   logic [1:0]                step_q, step_d;     // byte phase of the transaction
   logic [CW-1:0]             cnt_q, cnt_d;       // STATUS reads in current poll
   logic                      rnw_q, rnw_d;
   logic [6:0]                dev_q, dev_d;
   logic [7:0]                reg_q, reg_d;
   logic [7:0]                wdata_q, wdata_d;
   logic [7:0]                rdata_q, rdata_d;
   logic [1:0]                err_q, err_d;
   logic                      req_ready_q, req_ready_d;
   logic                      rsp_valid_q, rsp_valid_d;
   logic                      psel_q, psel_d;
   logic                      penable_q, penable_d;
   logic                      pwrite_q, pwrite_d;
   logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [31:0]               pwdata_q, pwdata_d;

   logic          acc_done;
   logic          tip, al, rxack, ack_chk, last_step;
   logic [CW-1:0] cnt_inc;
   logic          launch;
   logic          acc_wr;
   logic [APB_ADDR_WIDTH-1:0] acc_addr;
   logic [7:0]    acc_byte;
   logic          unused_prdata;

   assign acc_done  = psel_q & penable_q & PREADY;
   assign tip       = PRDATA[1];
   assign al        = PRDATA[5];
   assign rxack     = PRDATA[7];
   // The final read phase (CMD=0x68) NACKs on purpose, so RXACK is ignored there.
   assign ack_chk   = !(rnw_q && step_q == 2'd3);
   assign last_step = rnw_q ? (step_q == 2'd3) : (step_q == 2'd2);
   assign cnt_inc   = cnt_q + CW'(1);
   assign unused_prdata = ^PRDATA[31:8];

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      cnt_d       = cnt_q;
      rnw_d       = rnw_q;
      dev_d       = dev_q;
      reg_d       = reg_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      launch      = 1'b0;
      acc_wr      = 1'b0;
      acc_addr    = A_PRE;
      acc_byte    = 8'h00;

      if (psel_q && !penable_q) penable_d = 1'b1;

      case (state_q)
         // Bus errors during init are not reported: no client is waiting yet.
         S_PRE:  if (acc_done) state_d = S_CTRL;
         S_CTRL: if (acc_done) state_d = S_IDLE;
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               rnw_d   = req_rnw;
               dev_d   = req_dev;
               reg_d   = req_reg;
               wdata_d = req_wdata;
               step_d  = 2'd0;
               rdata_d = 8'h00;
               err_d   = 2'b00;
               state_d = S_TX;
            end
         end
         S_TX: begin
            if (acc_done) begin
               if (PSLVERR) begin err_d = 2'b11; state_d = S_ABCMD; end
               else state_d = S_CMD;
            end
         end
         S_CMD: begin
            if (acc_done) begin
               if (PSLVERR) begin err_d = 2'b11; state_d = S_ABCMD; end
               else begin cnt_d = '0; state_d = S_POLL; end
            end
         end
         S_POLL: begin
            if (acc_done) begin
               cnt_d = cnt_inc;
               if (PSLVERR) begin
                  err_d = 2'b11; state_d = S_ABCMD;
               end else if (al) begin
                  // Bus is no longer ours: finish without issuing STOP.
                  err_d = 2'b10; state_d = S_DONE;
               end else if (!tip) begin
                  if (ack_chk && rxack) begin
                     err_d = 2'b01; state_d = S_ABCMD;
                  end else if (last_step) begin
                     state_d = rnw_q ? S_RX : S_DONE;
                  end else begin
                     step_d  = step_q + 2'd1;
                     // Read phase 3 is a bare command with no TX byte.
                     state_d = (step_q == 2'd2) ? S_CMD : S_TX;
                  end
               end else if (cnt_inc == POLL_MAX) begin
                  err_d = 2'b11; state_d = S_ABCMD;
               end
            end
         end
         S_RX: begin
            if (acc_done) begin
               if (PSLVERR) begin err_d = 2'b11; state_d = S_ABCMD; end
               else begin rdata_d = PRDATA[7:0]; state_d = S_DONE; end
            end
         end
         S_ABCMD: begin
            if (acc_done) begin
               if (PSLVERR) begin err_d = 2'b11; state_d = S_DONE; end
               else state_d = S_ABPOLL;
            end
         end
         S_ABPOLL: begin
            // Single STATUS read to let the STOP settle; its content is ignored.
            if (acc_done) begin
               if (PSLVERR) err_d = 2'b11;
               state_d = S_DONE;
            end
         end
         S_DONE:  if (rsp_ready) state_d = S_IDLE;
         default: state_d = S_PRE;
      endcase

      // Access owned by the state we are heading into.
      case (state_d)
         S_PRE:   begin launch = 1'b1; acc_wr = 1'b1; acc_addr = A_PRE; end
         S_CTRL:  begin launch = 1'b1; acc_wr = 1'b1; acc_addr = A_CTRL; acc_byte = 8'h80; end
         S_TX: begin
            launch = 1'b1; acc_wr = 1'b1; acc_addr = A_TX;
            case (step_d)
               2'd0:    acc_byte = {dev_d, 1'b0};
               2'd1:    acc_byte = reg_d;
               2'd2:    acc_byte = rnw_d ? {dev_d, 1'b1} : wdata_d;
               default: acc_byte = 8'h00;
            endcase
         end
         S_CMD: begin
            launch = 1'b1; acc_wr = 1'b1; acc_addr = A_CMD;
            case (step_d)
               2'd0:    acc_byte = 8'h90;
               2'd1:    acc_byte = 8'h10;
               2'd2:    acc_byte = rnw_d ? 8'h90 : 8'h50;
               default: acc_byte = 8'h68;
            endcase
         end
         S_POLL, S_ABPOLL: begin launch = 1'b1; acc_addr = A_STATUS; end
         S_RX:    begin launch = 1'b1; acc_addr = A_RX; end
         S_ABCMD: begin launch = 1'b1; acc_wr = 1'b1; acc_addr = A_CMD; acc_byte = 8'h40; end
         default: launch = 1'b0;
      endcase

      if (acc_done) begin
         psel_d    = 1'b0;
         penable_d = 1'b0;
      end
      // New SETUP either back-to-back after a completed access or from an idle bus.
      if (launch && (acc_done || !psel_q)) begin
         psel_d    = 1'b1;
         penable_d = 1'b0;
         pwrite_d  = acc_wr;
         paddr_d   = acc_addr;
         if (state_d == S_PRE) pwdata_d = {16'h0000, PRESCALE};
         else                  pwdata_d = {24'h000000, acc_byte};
      end
   end

   assign req_ready_d = (state_d == S_IDLE);
   assign rsp_valid_d = (state_d == S_DONE);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= S_PRE;
         step_q      <= 2'd0;
         cnt_q       <= '0;
         rnw_q       <= 1'b0;
         dev_q       <= 7'h00;
         reg_q       <= 8'h00;
         wdata_q     <= 8'h00;
         rdata_q     <= 8'h00;
         err_q       <= 2'b00;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= 32'h0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         cnt_q       <= cnt_d;
         rnw_q       <= rnw_d;
         dev_q       <= dev_d;
         reg_q       <= reg_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;

endmodule

// File: doc/i2c_xfer_sequencer.md
Name: i2c_xfer_sequencer

Overview:
- Autonomous APB master that sequences the APB I2C master peripheral to perform complete register-style I2C transactions: device-address, register-address, then one data byte written or read.
- Sits between a simple request/response client (boot loader, sensor poller) and the I2C peripheral's APB slave port, connected point-to-point.
- Performs one-time core init after reset, then runs each request as a fixed sequence of register writes and STATUS polls. Reports data plus an error code.

Parameters:
- APB_ADDR_WIDTH, 12, width of PADDR.
- PRESCALE, 16'd99, value written to the peripheral's clock prescaler register at init.
- POLL_LIMIT, 4096, maximum STATUS reads per poll before timeout; counter width is $clog2(POLL_LIMIT+1).

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  async active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  sequencer can accept a request
- req_rnw  in  1  1 = read, 0 = write
- req_dev  in  7  7-bit I2C device address
- req_reg  in  8  device register address
- req_wdata  in  8  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_rdata  out  8  read data; 0 for writes and errors
- rsp_err  out  2  00 ok, 01 NACK, 10 arbitration lost, 11 timeout/PSLVERR
- PADDR  out  APB_ADDR_WIDTH  byte offset: PRE 0x00, CTRL 0x04, RX 0x08, STATUS 0x0C, TX 0x10, CMD 0x14
- PWDATA  out  32  write data, zero-extended
- PWRITE  out  1  APB write
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Behaviour:
- Reset: HRESETn is asynchronous and active-low; HCLK is the clock. Every output is 0 during reset. The state machine enters INIT, and request/response state is discarded. A reset mid-transaction abandons the bus; the peripheral is reset by the same HRESETn.
- APB protocol: every access is SETUP (PSEL=1, PENABLE=0) for one cycle, then ACCESS (PSEL=1, PENABLE=1) until PREADY=1.
  - PRDATA is captured on the PREADY cycle.
  - PADDR, PWDATA and PWRITE are stable from SETUP through ACCESS. PSEL=0 between accesses.
  - Minimum 2 cycles per access; back-to-back accesses are allowed.
- INIT: write PRE=PRESCALE, then CTRL=0x80 (core enable, interrupt disabled), then go to IDLE.
- IDLE: req_ready=1 only in IDLE with rsp_valid=0. Request fields are latched on req_valid && req_ready.
- Command encodings written to CMD: STA=0x80, STO=0x40, RD=0x20, WR=0x10, ACK=0x08.
- Write sequence:
  1. TX={dev,0}; CMD=0x90; POLL
  2. TX=reg; CMD=0x10; POLL
  3. TX=wdata; CMD=0x50; POLL
  4. DONE
- Read sequence:
  1. TX={dev,0}; CMD=0x90; POLL
  2. TX=reg; CMD=0x10; POLL
  3. TX={dev,1}; CMD=0x90 (repeated start); POLL
  4. CMD=0x68 (read, NACK, stop); POLL without ACK check
  5. Read RX; DONE
- POLL: read STATUS repeatedly until bit1 (TIP)=0.
  - The first poll read starts the cycle after the CMD write completes.
  - The poll counter resets at each POLL entry and increments per STATUS read.
  - The AL check (bit5=1) takes priority over the ACK check: err=10, go to DONE with no STOP.
  - Otherwise, if the ACK check is enabled and bit7 (RXACK)=1: err=01, go to ABORT.
  - If POLL_LIMIT reads complete with TIP still 1: err=11, go to ABORT.
- PSLVERR=1 on any access: err=11; go to ABORT, or to DONE if the error occurred inside ABORT.
- ABORT: write CMD=0x40, poll once without checks (the ABORT poll result does not override err), then go to DONE.
- DONE: rsp_valid=1 with rdata and err. rdata is RX[7:0] only for a successful read. The response is held stable until rsp_ready; the sequencer returns to IDLE the cycle after the handshake.
- Any req_valid while busy or while the response is pending is ignored (req_ready=0).
- No combinational path from req_*/rsp_ready to APB outputs; all outputs are registered.

Test Plan:
- Reset release with a peripheral model → APB writes PRE=0x0063 (PRESCALE=99) then CTRL=0x80 observed in that order; req_ready rises after the CTRL write. Each access holds SETUP 1 cycle and ACCESS until PREADY, including an injected 3-wait-state case.
- Write dev=0x50, reg=0x12, data=0xA5, slave ACKs all bytes → TX writes 0xA0, 0x12, 0xA5; CMD writes 0x90, 0x10, 0x50; rsp_err=00, rsp_rdata=0x00.
- Read dev=0x50, reg=0x34, slave returns 0x5C → CMD sequence 0x90, 0x10, 0x90, 0x68; TX third write 0xA1; rsp_rdata=0x5C, rsp_err=00.
- Device address NACK (STATUS returns RXACK=1) → CMD=0x40 written, no further TX writes; rsp_err=01. Arbitration loss (AL=1) → no STOP written; rsp_err=10.
- TIP stuck at 1 with POLL_LIMIT=8 → exactly 8 STATUS reads, then CMD=0x40; rsp_err=11. Separately, PSLVERR on the TX write → rsp_err=11.
- rsp_ready held low 20 cycles while req_valid=1 → response stable and req_ready=0 throughout. HRESETn pulsed low mid-POLL → PSEL/PENABLE/rsp_valid drop asynchronously and INIT repeats.
